// File: rtl/ifetch_unit_if.sv
// Fetch-stage bundle: redirect/control inputs, icache request/response, decode valid/ready.
interface ifetch_unit_if;
   logic        fetch_en;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic [15:0] ic_address;
   logic        ic_rd;
   logic [3:0]  ic_wr;
   logic        ic_data_ready;
   logic [31:0] ic_data;
   logic        inst_valid;
   logic [31:0] inst;
   logic [15:0] inst_pc;
   logic        inst_ready;

   modport master (
      input  fetch_en, redirect, redirect_pc, ic_data_ready, ic_data, inst_ready,
      output ic_address, ic_rd, ic_wr, inst_valid, inst, inst_pc
   );

   modport slave (
      output fetch_en, redirect, redirect_pc, ic_data_ready, ic_data, inst_ready,
      input  ic_address, ic_rd, ic_wr, inst_valid, inst, inst_pc
   );
endinterface

// File: rtl/ifetch_unit.sv
// Fetch stage: one outstanding icache read (2 cycles/word on hits), words buffered with their PC for decode;
// stops issuing when buffer plus in-flight word would overflow. IFETCH_STATS_EN adds fetch/stall counters.
module ifetch_unit #(
   parameter logic [15:0] RESET_PC   = 16'h0000,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   ifetch_unit_if.master bus
`ifdef IFETCH_STATS_EN
   ,
   output logic [31:0]   fetch_count,
   output logic [31:0]   stall_cycles
`endif
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] DROP = 2'd2;

   logic [1:0]    state;
   logic [15:0]   pc;
   logic [15:0]   drop_pc;
   logic [15:0]   new_pc;
   logic [15:0]   buf_pc  [FIFO_DEPTH];
   logic [31:0]   buf_dat [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;
   logic          push;
   logic          pop;
   logic          start;

   assign new_pc = bus.redirect_pc & 16'hFFFC;
   assign push   = (state == REQ) && bus.ic_data_ready && !bus.redirect;
   assign pop    = (count != '0) && bus.inst_ready && !bus.redirect;

   // The in-flight word is counted against capacity before issue, so a push always finds room.
   always_comb begin
      count_next = count + CW'(push) - CW'(pop);
      if (bus.redirect)
         count_next = '0;
   end

   assign start = bus.fetch_en && (count_next < CW'(FIFO_DEPTH));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         pc      <= RESET_PC;
         drop_pc <= RESET_PC;
      end else begin
         case (state)
            IDLE: begin
               if (bus.redirect)
                  pc <= new_pc;
               if (start)
                  state <= REQ;
            end
            REQ: begin
               if (bus.ic_data_ready) begin
                  pc    <= bus.redirect ? new_pc : pc + 16'd4;
                  state <= start ? REQ : IDLE;
               end else if (bus.redirect) begin
                  drop_pc <= new_pc;
                  state   <= DROP;
               end
            end
            DROP: begin
               // Address stays on the abandoned request until the icache finishes it.
               if (bus.ic_data_ready) begin
                  pc    <= bus.redirect ? new_pc : drop_pc;
                  state <= start ? REQ : IDLE;
               end else if (bus.redirect) begin
                  drop_pc <= new_pc;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (bus.redirect) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         count <= count_next;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         buf_pc[wr_ptr]  <= pc;
         buf_dat[wr_ptr] <= bus.ic_data;
      end
   end

   assign bus.ic_rd      = (state != IDLE);
   assign bus.ic_address = pc;
   assign bus.ic_wr      = 4'b0000;
   assign bus.inst_valid = (count != '0);
   assign bus.inst       = buf_dat[rd_ptr];
   assign bus.inst_pc    = buf_pc[rd_ptr];

`ifdef IFETCH_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_count  <= '0;
         stall_cycles <= '0;
      end else begin
         if (push && (fetch_count != 32'hFFFF_FFFF))
            fetch_count <= fetch_count + 32'd1;
         if (bus.ic_rd && !bus.ic_data_ready && (stall_cycles != 32'hFFFF_FFFF))
            stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: icache responder, queue-based fetch model checked every cycle, directed scenarios.
module tb_ifetch_unit;
   localparam logic [15:0] RST_PC = 16'h0040;
   localparam int          DEPTH  = 4;

   typedef struct packed {
      logic [15:0] pc;
      logic [31:0] dat;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   logic [15:0] miss_addr = 16'h0001;
   int          miss_lat = 13;
   logic        busy;
   int          ready_cyc;
   logic [15:0] req_addr;

   ifetch_unit_if bus ();
`ifdef IFETCH_STATS_EN
   logic [31:0] fetch_count;
   logic [31:0] stall_cycles;
`endif

   ifetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef IFETCH_STATS_EN
      ,
      .fetch_count  (fetch_count),
      .stall_cycles (stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memf(input logic [15:0] a);
      return {a ^ 16'hBEEF, ~a};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // icache: samples rd in its idle cycle, answers 1 cycle later on a hit, miss_lat cycles on a miss.
   initial begin
      bus.ic_data_ready = 1'b0;
      bus.ic_data       = 32'hDEAD_DEAD;
      busy              = 1'b0;
      ready_cyc         = 0;
      req_addr          = 16'h0000;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (!rst_n) begin
            busy = 1'b0;
            bus.ic_data_ready = 1'b0;
            continue;
         end
         if (bus.ic_data_ready) begin
            bus.ic_data_ready = 1'b0;
            bus.ic_data       = 32'hDEAD_DEAD;
            busy              = 1'b0;
         end
         if (!busy && bus.ic_rd) begin
            busy      = 1'b1;
            req_addr  = bus.ic_address;
            ready_cyc = cyc + ((bus.ic_address == miss_addr) ? miss_lat : 1);
         end
         if (busy && cyc == ready_cyc) begin
            bus.ic_data_ready = 1'b1;
            bus.ic_data       = memf(req_addr);
         end
      end
   end

   // Reference model: ordered stream of fetched words, next fetch PC, and a pending-discard marker.
   initial begin
      ent_t        q[$];
      logic [15:0] m_pc;
      logic [15:0] m_hold;
      logic        m_drop;
      m_pc   = RST_PC;
      m_hold = RST_PC;
      m_drop = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            q.delete();
            m_pc   = RST_PC;
            m_drop = 1'b0;
            continue;
         end
         check("m_inst_valid", 32'(bus.inst_valid), 32'(q.size() != 0));
         if (q.size() != 0) begin
            check("m_inst_pc", 32'(bus.inst_pc), 32'(q[0].pc));
            check("m_inst", bus.inst, q[0].dat);
         end
         check("m_ic_wr", 32'(bus.ic_wr), 32'd0);
         if (m_drop) begin
            check("m_drop_addr", 32'(bus.ic_address), 32'(m_hold));
            check("m_drop_rd", 32'(bus.ic_rd), 32'd1);
         end else begin
            check("m_ic_address", 32'(bus.ic_address), 32'(m_pc));
            if (bus.ic_rd)
               check("m_room", 32'(q.size() < DEPTH), 32'd1);
         end
         if (!bus.redirect && bus.inst_ready && q.size() != 0)
            void'(q.pop_front());
         if (bus.ic_rd && bus.ic_data_ready) begin
            if (m_drop) begin
               m_drop = 1'b0;
            end else if (!bus.redirect) begin
               q.push_back({m_pc, memf(m_pc)});
               m_pc = m_pc + 16'd4;
            end
         end
         if (bus.redirect) begin
            q.delete();
            if (bus.ic_rd && !bus.ic_data_ready && !m_drop) begin
               m_drop = 1'b1;
               m_hold = m_pc;
            end
            m_pc = bus.redirect_pc & 16'hFFFC;
         end
      end
   end

   task automatic wait_done(output logic [15:0] a, output int c);
      int n;
      n = 0;
      @(negedge clk);
      while (!(bus.ic_rd && bus.ic_data_ready) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!(bus.ic_rd && bus.ic_data_ready)) begin
         total++;
         bad++;
         $display("FAIL done_timeout: no icache completion within 200 cycles");
      end
      a = bus.ic_address;
      c = cyc;
   endtask

   task automatic wait_addr(input logic [15:0] t);
      logic [15:0] a;
      int          c;
      logic        hit;
      hit = 1'b0;
      for (int i = 0; i < 20 && !hit; i++) begin
         wait_done(a, c);
         hit = (a == t);
      end
      if (!hit) begin
         total++;
         bad++;
         $display("FAIL addr_timeout: no completion at %h, last %h", t, a);
      end
   endtask

   task automatic do_redirect(input logic [15:0] p);
      @(posedge clk);
      #1;
      bus.redirect    = 1'b1;
      bus.redirect_pc = p;
      @(posedge clk);
      #1;
      bus.redirect = 1'b0;
   endtask

   initial begin
      logic [15:0] a0, a1, a2;
      int          c0, c1, c2, n, rises;
      logic        prev_rd, moved;
`ifdef IFETCH_STATS_EN
      logic [31:0] f0, s0;
`endif
      bus.fetch_en    = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 16'h0000;
      bus.inst_ready  = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state
      @(negedge clk);
      check("rst_ic_rd", 32'(bus.ic_rd), 32'd0);
      check("rst_ic_address", 32'(bus.ic_address), 32'h0040);
      check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
      check("rst_ic_wr", 32'(bus.ic_wr), 32'd0);
`ifdef IFETCH_STATS_EN
      check("rst_fetch_count", fetch_count, 32'd0);
      check("rst_stall_cycles", stall_cycles, 32'd0);
`endif

      // Hit streaming from reset PC
      @(posedge clk);
      #1 bus.fetch_en = 1'b1;
      wait_done(a0, c0);
      wait_done(a1, c1);
      wait_done(a2, c2);
      check("hit_addr0", 32'(a0), 32'h0040);
      check("hit_addr1", 32'(a1), 32'h0044);
      check("hit_addr2", 32'(a2), 32'h0048);
      check("hit_spacing01", 32'(c1 - c0), 32'd2);
      check("hit_spacing12", 32'(c2 - c1), 32'd2);
      @(negedge clk);
      check("hit_inst_valid", 32'(bus.inst_valid), 32'd1);
      check("hit_inst_pc", 32'(bus.inst_pc), 32'h0048);
      check("hit_inst", bus.inst, memf(16'h0048));

      // Miss at 0x0100: request held stable for the full latency
      miss_addr = 16'h0100;
      do_redirect(16'h0100);
      n = 0;
      @(negedge clk);
      while (!(bus.ic_rd && bus.ic_address == 16'h0100) && n < 50) begin
         @(negedge clk);
         n++;
      end
`ifdef IFETCH_STATS_EN
      s0 = stall_cycles;
`endif
      n = 0;
      moved = 1'b0;
      while (bus.ic_rd && !bus.ic_data_ready && n < 50) begin
         if (bus.ic_address != 16'h0100)
            moved = 1'b1;
         n++;
         @(negedge clk);
      end
      check("miss_stall_len", 32'(n), 32'd13);
      check("miss_addr_stable", 32'(moved), 32'd0);
      check("miss_done_addr", 32'(bus.ic_address), 32'h0100);
`ifdef IFETCH_STATS_EN
      check("miss_stall_cycles", stall_cycles - s0, 32'd13);
`endif
      @(negedge clk);
      check("miss_inst_pc", 32'(bus.inst_pc), 32'h0100);
      check("miss_inst", bus.inst, memf(16'h0100));
      miss_addr = 16'h0001;

      // Redirect coinciding with a completion
      n = 0;
      @(negedge clk);
      while (!(bus.ic_rd && !bus.ic_data_ready) && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      bus.redirect    = 1'b1;
      bus.redirect_pc = 16'h0500;
      @(negedge clk);
      check("coin_ready", 32'(bus.ic_data_ready), 32'd1);
      @(posedge clk);
      #1 bus.redirect = 1'b0;
      @(negedge clk);
      check("coin_next_addr", 32'(bus.ic_address), 32'h0500);
      check("coin_not_pushed", 32'(bus.inst_valid), 32'd0);
      wait_done(a0, c0);
      check("coin_done_addr", 32'(a0), 32'h0500);

      // PC wrap
      do_redirect(16'hFFFC);
      wait_addr(16'hFFFC);
`ifdef IFETCH_STATS_EN
      f0 = fetch_count;
`endif
      wait_done(a0, c0);
      check("wrap_addr", 32'(a0), 32'h0000);
`ifdef IFETCH_STATS_EN
      check("wrap_fetch_count", fetch_count - f0, 32'd1);
`endif

      // Fill with decode stalled, then release one slot
      @(posedge clk);
      #1 bus.inst_ready = 1'b0;
      do_redirect(16'h0300);
      repeat (30) @(negedge clk);
      check("full_ic_rd", 32'(bus.ic_rd), 32'd0);
      check("full_head_pc", 32'(bus.inst_pc), 32'h0300);
      check("full_ic_address", 32'(bus.ic_address), 32'h0310);
      @(posedge clk);
      #1 bus.inst_ready = 1'b1;
      @(posedge clk);
      #1 bus.inst_ready = 1'b0;
      rises = 0;
      prev_rd = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.ic_rd && !prev_rd)
            rises++;
         prev_rd = bus.ic_rd;
      end
      check("pop_one_request", 32'(rises), 32'd1);
      check("pop_ic_rd", 32'(bus.ic_rd), 32'd0);
      check("pop_head_pc", 32'(bus.inst_pc), 32'h0304);
      check("pop_ic_address", 32'(bus.ic_address), 32'h0314);

      // Redirect during a miss: old data dropped, unaligned target aligned
      miss_addr = 16'h0010;
      do_redirect(16'h0010);
      bus.inst_ready = 1'b1;
      @(negedge clk);
      check("flush_inst_valid", 32'(bus.inst_valid), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      bus.redirect    = 1'b1;
      bus.redirect_pc = 16'h0203;
      @(posedge clk);
      #1 bus.redirect = 1'b0;
      @(negedge clk);
      check("drop_hold_addr", 32'(bus.ic_address), 32'h0010);
      check("drop_hold_rd", 32'(bus.ic_rd), 32'd1);
      wait_done(a0, c0);
      wait_done(a1, c1);
      check("drop_first_done", 32'(a0), 32'h0010);
      check("drop_next_req", 32'(a1), 32'h0200);
      @(negedge clk);
      check("drop_inst_pc", 32'(bus.inst_pc), 32'h0200);
      miss_addr = 16'h0001;

      repeat (5) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end
endmodule
